// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port memory between IF and LS with LS priority,
// bounded IF starvation, and tagged read-response routing after a fixed latency.
module imem_dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_LS_RUN = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_stall_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [31:0]       ls_wdata_i,
    input  logic [3:0]        ls_bmask_i,
    output logic              ls_gnt_o,
    output logic              ls_stall_o,
    output logic              ls_rvalid_o,
    output logic [31:0]       ls_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_bmask_o,
    input  logic [31:0]       mem_rdata_i
);
    logic [3:0]            run_cnt;
    logic [RD_LATENCY-1:0] tag_v;
    logic [RD_LATENCY-1:0] tag_ls;
    logic                  run_full;
    logic                  rd_push;
    logic                  rsp_if;
    logic                  rsp_ls;
    always_comb begin
        run_full    = run_cnt >= 4'(MAX_LS_RUN);
        ls_gnt_o    = ls_req_i & (~if_req_i | ~run_full);
        if_gnt_o    = if_req_i & ~ls_gnt_o;
        if_stall_o  = if_req_i & ~if_gnt_o;
        ls_stall_o  = ls_req_i & ~ls_gnt_o;
        mem_req_o   = if_gnt_o | ls_gnt_o;
        mem_we_o    = ls_gnt_o & ls_we_i;
        mem_addr_o  = ls_gnt_o ? ls_addr_i : (if_gnt_o ? if_addr_i : '0);
        mem_wdata_o = ls_gnt_o ? ls_wdata_i : '0;
        mem_bmask_o = mem_we_o ? ls_bmask_i : 4'b0000;
        rd_push     = if_gnt_o | (ls_gnt_o & ~ls_we_i);
        rsp_if      = tag_v[RD_LATENCY-1] & ~tag_ls[RD_LATENCY-1];
        rsp_ls      = tag_v[RD_LATENCY-1] & tag_ls[RD_LATENCY-1];
    end
    // Run counter only matters while IF is waiting; any IF grant or idle IF restarts it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            run_cnt <= '0;
        else if (!if_req_i || if_gnt_o)
            run_cnt <= '0;
        else if (ls_gnt_o && !run_full)
            run_cnt <= run_cnt + 4'd1;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_v  <= '0;
            tag_ls <= '0;
        end else begin
            tag_v[0]  <= rd_push;
            tag_ls[0] <= ls_gnt_o;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_ls[i] <= tag_ls[i-1];
            end
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            if_rvalid_o <= 1'b0;
            ls_rvalid_o <= 1'b0;
            if_rdata_o  <= '0;
            ls_rdata_o  <= '0;
        end else begin
            if_rvalid_o <= rsp_if;
            ls_rvalid_o <= rsp_ls;
            if (rsp_if)
                if_rdata_o <= mem_rdata_i;
            if (rsp_ls)
                ls_rdata_o <= mem_rdata_i;
        end
    end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: scoreboard bench; grants checked against a reference arbiter,
// expected read responses queued at grant and matched against rvalid pulses.
module tb_imem_dmem_arbiter;
    localparam int LAT  = 2;
    localparam int MAXR = 3;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        if_req_i, ls_req_i, ls_we_i;
    logic [31:0] if_addr_i, ls_addr_i, ls_wdata_i;
    logic [3:0]  ls_bmask_i;
    logic        if_gnt_o, if_stall_o, if_rvalid_o;
    logic        ls_gnt_o, ls_stall_o, ls_rvalid_o;
    logic [31:0] if_rdata_o, ls_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_bmask_o;

    imem_dmem_arbiter #(.ADDR_W(32), .RD_LATENCY(LAT), .MAX_LS_RUN(MAXR)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_stall_o(if_stall_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
        .ls_wdata_i(ls_wdata_i), .ls_bmask_i(ls_bmask_i), .ls_gnt_o(ls_gnt_o),
        .ls_stall_o(ls_stall_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_bmask_o(mem_bmask_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a < 32'h100) ? 32'h0000_0013 : {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Memory model: read data appears LAT cycles after the request, garbage otherwise.
    logic [31:0] pipe_d [LAT];
    logic        pipe_v [LAT];
    always @(posedge clk) begin
        pipe_v[0] <= mem_req_o & ~mem_we_o;
        pipe_d[0] <= mem_fn(mem_addr_o);
        for (int i = 1; i < LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign mem_rdata_i = (pipe_v[LAT-1] === 1'b1) ? pipe_d[LAT-1] : 32'hDEAD_BEEF;

    typedef struct {
        logic        is_ls;
        logic [31:0] data;
        int          cyc;
    } rsp_t;
    rsp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          run_m   = 0;
    logic [31:0] last_if = '0;
    logic [31:0] last_ls = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_resp();
        rsp_t r;
        check("dual_rvalid", 32'(if_rvalid_o & ls_rvalid_o), 0);
        while (q.size() != 0 && q[0].cyc < cyc) begin
            check("missed_rsp_cyc", 32'(cyc), 32'(q[0].cyc));
            void'(q.pop_front());
        end
        if (if_rvalid_o || ls_rvalid_o) begin
            check("rsp_pending", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                r = q.pop_front();
                check("rsp_port", 32'(ls_rvalid_o), 32'(r.is_ls));
                check("rsp_cyc", 32'(cyc), 32'(r.cyc));
                check("rsp_data", ls_rvalid_o ? ls_rdata_o : if_rdata_o, r.data);
                if (r.is_ls) last_ls = r.data;
                else last_if = r.data;
            end
        end else begin
            check("rvalid_due", 32'(q.size() != 0 && q[0].cyc == cyc), 0);
        end
        if (!if_rvalid_o) check("if_rdata_hold", if_rdata_o, last_if);
        if (!ls_rvalid_o) check("ls_rdata_hold", ls_rdata_o, last_ls);
    endtask

    // Called just after a falling edge: drive, check grants/mux, advance one cycle.
    task automatic step(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                        input logic [31:0] la, input logic [31:0] wd, input logic [3:0] bm);
        logic eg_if, eg_ls;
        if_req_i = ir; if_addr_i = ia;
        ls_req_i = lr; ls_we_i = lw; ls_addr_i = la; ls_wdata_i = wd; ls_bmask_i = bm;
        #1;
        eg_ls = lr && (!ir || run_m < MAXR);
        eg_if = ir && !eg_ls;
        check("if_gnt", 32'(if_gnt_o), 32'(eg_if));
        check("ls_gnt", 32'(ls_gnt_o), 32'(eg_ls));
        check("if_stall", 32'(if_stall_o), 32'(ir && !eg_if));
        check("ls_stall", 32'(ls_stall_o), 32'(lr && !eg_ls));
        check("mem_req", 32'(mem_req_o), 32'(eg_if || eg_ls));
        if (eg_ls) begin
            check("mem_addr_ls", mem_addr_o, la);
            check("mem_we_ls", 32'(mem_we_o), 32'(lw));
            check("mem_bmask_ls", 32'(mem_bmask_o), lw ? 32'(bm) : 0);
            if (lw) check("mem_wdata_st", mem_wdata_o, wd);
            else q.push_back('{1'b1, mem_fn(la), cyc + LAT + 1});
        end else if (eg_if) begin
            check("mem_addr_if", mem_addr_o, ia);
            check("mem_we_if", 32'(mem_we_o), 0);
            check("mem_bmask_if", 32'(mem_bmask_o), 0);
            q.push_back('{1'b0, mem_fn(ia), cyc + LAT + 1});
        end else begin
            check("mem_addr_idle", mem_addr_o, 0);
            check("mem_wdata_idle", mem_wdata_o, 0);
        end
        if (!ir || eg_if) run_m = 0;
        else if (eg_ls && run_m < MAXR) run_m++;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_resp();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        if_req_i = 0; ls_req_i = 0; ls_we_i = 0;
        if_addr_i = 0; ls_addr_i = 0; ls_wdata_i = 0; ls_bmask_i = 0;
        #1;
        check("rst_if_rvalid", 32'(if_rvalid_o), 0);
        check("rst_ls_rvalid", 32'(ls_rvalid_o), 0);
        check("rst_if_rdata", if_rdata_o, 0);
        check("rst_ls_rdata", ls_rdata_o, 0);
        check("rst_mem_req", 32'(mem_req_o), 0);
        check("rst_mem_we", 32'(mem_we_o), 0);
        check("rst_if_gnt", 32'(if_gnt_o), 0);
        check("rst_ls_gnt", 32'(ls_gnt_o), 0);
        q.delete();
        run_m = 0; last_if = '0; last_ls = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b1;
        #2;
        do_reset();
        // Fetch-only stream of NOPs
        step(1, 32'h0, 0, 0, 0, 0, 0);
        step(1, 32'h4, 0, 0, 0, 0, 0);
        step(1, 32'h8, 0, 0, 0, 0, 0);
        idle(LAT + 2);
        // Simultaneous IF and load: LS first, IF next cycle
        step(1, 32'h10, 1, 0, 32'h2000, 0, 0);
        step(1, 32'h10, 0, 0, 0, 0, 0);
        idle(LAT + 2);
        // Both held: LS,LS,LS,IF repeating
        for (int i = 0; i < 12; i++)
            step(1, 32'h400 + 32'(i * 4), 1, 0, 32'h3000 + 32'(i * 4), 0, 0);
        idle(LAT + 2);
        // Store to LEDR: no response
        step(0, 0, 1, 1, 32'h7000, 32'h0002_ABCD, 4'hF);
        idle(LAT + 3);
        // Alternating IF/LS reads
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(1, 32'h800 + 32'(i * 4), 0, 0, 0, 0, 0);
            else step(0, 0, 1, 0, 32'h5000 + 32'(i * 4), 0, 0);
        end
        idle(LAT + 2);
        // Random traffic including stores, withdrawals and contention
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 1023) << 2),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 32'h6000 + 32'($urandom_range(0, 1023) << 2), $urandom, 4'($urandom_range(1, 15)));
        idle(LAT + 2);
        // Reset one cycle after a load grant: in-flight read must vanish
        step(0, 0, 1, 0, 32'h2040, 0, 0);
        do_reset();
        idle(LAT + 3);
        step(1, 32'h24, 0, 0, 0, 0, 0);
        idle(LAT + 2);
        check("queue_empty", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port synchronous memory between the RV32I pipeline's instruction-fetch (IF) stage and its load/store (LS) stage.
- Grants at most one access per cycle. LS has fixed priority, with a bounded-starvation rule for IF.
- Returns read data to the correct requester after a fixed memory latency.
- Sits between the pipeline core and the unified memory/IO map (switches, LEDs, HEX, LCD). Its `if_stall_o` and `ls_stall_o` feed the hazard unit.

Parameters:
- ADDR_W, 32, byte address width of both ports and memory.
- RD_LATENCY, 1, memory read latency in cycles from accepted request to `mem_rdata_i` valid; legal range 1..4.
- MAX_LS_RUN, 3, maximum consecutive LS grants while an IF request waits; legal range 1..15.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request, held until granted
- if_addr_i  in  ADDR_W  fetch address, word aligned
- if_gnt_o  out  1  fetch request accepted this cycle
- if_stall_o  out  1  if_req_i & ~if_gnt_o
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  32  fetch data
- ls_req_i  in  1  load/store request, held until granted
- ls_we_i  in  1  1 = store, 0 = load
- ls_addr_i  in  ADDR_W  load/store address
- ls_wdata_i  in  32  store data
- ls_bmask_i  in  4  store byte enables
- ls_gnt_o  out  1  load/store accepted this cycle
- ls_stall_o  out  1  ls_req_i & ~ls_gnt_o
- ls_rvalid_o  out  1  load data valid; never asserted for stores
- ls_rdata_o  out  32  load data
- mem_req_o  out  1  memory access this cycle
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  32  memory write data
- mem_bmask_o  out  4  memory byte enables, 4'b0000 on reads
- mem_rdata_i  in  32  memory read data, valid RD_LATENCY cycles after a read request

Behaviour:
- Reset (async assert, sync release): `run_cnt`=0, response tag pipeline cleared. All `*_rvalid_o`=0 and `*_rdata_o`=0. `mem_req_o`=0, `mem_we_o`=0. A reset mid-transaction discards in-flight reads; no `rvalid` is emitted for them after release.
- Grant logic is combinational from requests and `run_cnt`, with one grant per cycle:
  - Only one requester: that requester is granted.
  - Both requesting and `run_cnt` < MAX_LS_RUN: LS granted.
  - Both requesting and `run_cnt` == MAX_LS_RUN: IF granted.
- `run_cnt` updates on every clock edge:
  - Increments on an LS grant while `if_req_i`=1, saturating at MAX_LS_RUN.
  - Clears on any IF grant, or whenever `if_req_i`=0.
- Memory mux: `mem_*` signals carry the granted port's fields. `mem_req_o`=`if_gnt_o`|`ls_gnt_o`. IF accesses drive `mem_we_o`=0 and `mem_bmask_o`=0. With no grant, `mem_addr_o`/`mem_wdata_o` hold 0.
- Response tagging: each granted read pushes a tag {valid, is_ls} into an RD_LATENCY-deep shift register; grants with no read push {0, x}.
  - At the stage-RD_LATENCY output, a valid tag with is_ls=0 → `if_rvalid_o`=1 and `if_rdata_o`=`mem_rdata_i` (registered: visible in the cycle after the data arrives, i.e. total latency RD_LATENCY+1 from grant).
  - A valid tag with is_ls=1 → same for `ls_rvalid_o` and `ls_rdata_o`.
  - Exactly one `rvalid` per granted read, in grant order.
- Stores complete on grant; they produce no response and occupy no tag.
- Back-to-back grants every cycle are legal; the tag pipeline never overflows since it advances every cycle.
- Requests are not required to be held after grant; the arbiter samples fields only in the grant cycle.
- A request withdrawn before grant is dropped silently.
- `rdata` outputs hold their last value while `rvalid`=0.

Test Plan:
- Reset then only `if_req_i`=1 at addresses 0x0, 0x4, 0x8 on consecutive cycles, memory returns 0x00000013 (NOP) → `if_gnt_o`=1 every cycle; `if_rvalid_o` pulses 3 consecutive cycles starting 2 cycles after first grant (RD_LATENCY=1), data 0x00000013.
- `if_req_i` and `ls_req_i` (load 0x2000) both asserted for one cycle → `ls_gnt_o`=1, `if_stall_o`=1 that cycle. IF granted next cycle. `ls_rvalid_o` precedes `if_rvalid_o` by exactly one cycle.
- Both requests held continuously, MAX_LS_RUN=3 → grant pattern LS,LS,LS,IF repeating; `run_cnt` never exceeds 3.
- Store `ls_we_i`=1, addr 0x7000 (LEDR), wdata 0x0002ABCD, bmask 4'b1111 → `mem_we_o`=1, `mem_bmask_o`=4'hF, `mem_wdata_o`=0x0002ABCD for one cycle; no `ls_rvalid_o` ever.
- Deassert `rst_ni` one cycle after a load grant, RD_LATENCY=2 → no `ls_rvalid_o` after reset release; all outputs 0 during reset.
- RD_LATENCY=4, alternating IF/LS reads every cycle for 8 cycles → 8 `rvalid` pulses, in grant order, each routed to its own port with matching data.
